store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum cycles spent waiting on mem_ready per memory access before aborting.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle store request pulse, accepted only when busy=0.
REQ-005 SHALL have port opcode, input, 6 [31:26]: store opcode, with sw=101011, sh=101001 and sb=101000.
REQ-006 SHALL have port addr, input, 32: byte address of the store.
REQ-007 SHALL have port din, input, 32: rt register value; the low byte, halfword or word is stored.
REQ-008 SHALL have port mem_addr, output, 32: word address to memory, formed as {addr[31:2],2'b00}.
REQ-009 SHALL have port mem_rd, output, 1: memory read strobe.
REQ-010 SHALL have port mem_wr, output, 1: memory write strobe.
REQ-011 SHALL have port mem_be, output, 4: byte enables, with bit i covering bits [8i+7:8i].
REQ-012 SHALL have port mem_wdata, output, 32: write data, with lanes aligned to mem_be.
REQ-013 SHALL have port mem_rdata, input, 32: read data, valid when mem_ready=1 during a read.
REQ-014 SHALL have port mem_ready, input, 1: memory completes the current rd/wr access in this cycle.
REQ-015 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port err, output, 2: completion status, valid with done; 00=ok, 01=misaligned, 10=timeout.

Function
REQ-018 SHALL generate byte enables as follows: sw gives 1111; sh gives 0011 when addr[1]=0 and 1100 when addr[1]=1; sb gives a one-hot mask at bit addr[1:0].
REQ-019 SHALL replicate data across lanes: sh gives {din[15:0],din[15:0]}; sb gives four copies of din[7:0]; sw gives din unchanged.
REQ-020 SHALL use FSM states IDLE, CHECK, READ, WRITE and FIN; READ exists only under STORE_RMW_EN.
REQ-021 SHALL, in IDLE with start=1, latch opcode, addr and din and go to CHECK; start while busy=1 SHALL be ignored.
REQ-022 SHALL treat an opcode that is not sw/sh/sb at CHECK as a no-op: FIN with err=00 and no memory strobes.
REQ-023 SHALL, in CHECK, go to FIN with err=01 and no memory access when sh has addr[0]=1 or sw has addr[1:0]!=00.
REQ-024 SHALL, in CHECK with an aligned address, go to WRITE (or READ, per REQ-032).
REQ-025 SHALL hold mem_rd or mem_wr high continuously in READ/WRITE until mem_ready=1, keeping mem_addr, mem_be and mem_wdata stable throughout.
REQ-026 SHALL count wait cycles with a counter that clears on entry to each access state; when the count reaches WAIT_MAX without mem_ready, it SHALL drop the strobe and go to FIN with err=10.
REQ-027 SHALL, when mem_ready=1 in WRITE, go to FIN with err=00.
REQ-028 SHALL, in FIN, pulse done for one cycle and return to IDLE; busy=0 in IDLE only.
REQ-029 SHALL take minimum latency from start to done of 3 cycles for a direct write with mem_ready already high, i.e. start at cycle 0 gives done at cycle 3.
REQ-030 SHALL treat mem_ready outside READ/WRITE as don't-care.

Reset
REQ-031 SHALL, while rst=1, immediately force IDLE with mem_rd=0, mem_wr=0, mem_be=0000, mem_wdata=0, mem_addr=0, busy=0, done=0, err=00 and the wait counter at 0; a mid-access reset aborts with no further strobes.

Configuration
REQ-032 SHALL, with macro STORE_RMW_EN defined, make sb/sh perform a read-modify-write: READ fetches the word, and WRITE drives merged data (mem_rdata bytes where mem_be=0, new bytes where mem_be=1) with mem_be=1111; sw skips READ.
REQ-033 SHALL, without STORE_RMW_EN, never assert mem_rd and drive sb/sh writes with partial mem_be; the READ state SHALL be absent.

Verification
REQ-034 SHALL cover: sb, addr=0x0000_1002, din=0x0000_00A5, mem_ready tied 1, no RMW -> mem_addr=0x1000, mem_be=0100, mem_wdata=0xA5A5A5A5, done at cycle 3, err=00.
REQ-035 SHALL cover: sh, addr=0x0000_2003 -> no mem_rd/mem_wr, done with err=01.
REQ-036 SHALL cover: STORE_RMW_EN, sh, addr=0x0000_0012, din=0x0000_BEEF, mem_rdata=0x11223344 -> read, then write mem_be=1111, mem_wdata=0xBEEF3344.
REQ-037 SHALL cover: sw with mem_ready held 0, WAIT_MAX=15 -> mem_wr high 15 cycles, then drops, done with err=10.
REQ-038 SHALL cover: rst asserted mid-WRITE -> strobes low in the same cycle, busy=0, and the next start is serviced normally.
REQ-039 SHALL cover: start pulsed while busy -> ignored, and exactly one done is produced.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: byte/halfword/word store engine driving a simple rd/wr memory port.
// Latches a store request and checks alignment. It then issues the memory write,
// or a read followed by a write when read-modify-write is enabled. Every wait on
// mem_ready is bounded by WAIT_MAX cycles.
// Build option: define STORE_RMW_EN to make sb/sh read the word first and write
// back a merged full word (mem_be=1111). Without it, sb/sh use partial byte enables.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// CHECK | decode latched opcode, check alignment
// READ  | (STORE_RMW_EN only) mem_rd held until mem_ready or timeout
// WRITE | mem_wr held until mem_ready or timeout
// FIN   | done pulse, err valid
module store_unit #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  // The wait counter is loaded with WAIT_MAX-1 and runs down to 0, so the strobe
  // stays high for exactly WAIT_MAX cycles before the access is abandoned.
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
`ifdef STORE_RMW_EN
    READ,
`endif
    WRITE,
    FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_opcode;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic [1:0]  r_err;
  logic [CW-1:0] r_wait;

  logic        w_is_sw;
  logic        w_is_sh;
  logic        w_is_sb;
  logic        w_valid_op;
  logic        w_misaligned;
  logic [3:0]  w_lane_be;
  logic [31:0] w_rep_data;
  logic [3:0]  w_wr_be;
  logic [31:0] w_wr_data;
  logic        w_latch;
  logic        w_load_wait;
  logic        w_dec_wait;
  logic        w_err_set;
  logic [1:0]  w_err_val;
  logic        w_access;

  assign w_is_sw    = (r_opcode == OP_SW);
  assign w_is_sh    = (r_opcode == OP_SH);
  assign w_is_sb    = (r_opcode == OP_SB);
  assign w_valid_op = w_is_sw | w_is_sh | w_is_sb;
  assign w_misaligned = (w_is_sh & r_addr[0]) | (w_is_sw & (r_addr[1:0] != 2'b00));

  // Byte lanes touched by the store and the source data replicated into every lane.
  always_comb begin
    w_lane_be  = 4'b0000;
    w_rep_data = 32'h0;
    if (w_is_sw) begin
      w_lane_be  = 4'b1111;
      w_rep_data = r_din;
    end else if (w_is_sh) begin
      w_lane_be  = r_addr[1] ? 4'b1100 : 4'b0011;
      w_rep_data = {2{r_din[15:0]}};
    end else if (w_is_sb) begin
      w_lane_be  = 4'b0001 << r_addr[1:0];
      w_rep_data = {4{r_din[7:0]}};
    end
  end

`ifdef STORE_RMW_EN
  logic [31:0] r_rdata;
  logic        w_cap_rdata;
  logic [31:0] w_merge;

  // Merge the fetched word with the new bytes; lanes outside the store keep memory data.
  always_comb begin
    w_merge = 32'h0;
    for (int i = 0; i < 4; i++) begin
      w_merge[8*i +: 8] = w_lane_be[i] ? w_rep_data[8*i +: 8] : r_rdata[8*i +: 8];
    end
  end

  assign w_wr_be   = 4'b1111;
  assign w_wr_data = w_is_sw ? r_din : w_merge;

  // Capture read data when the READ access completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'h0;
    end else if (w_cap_rdata) begin
      r_rdata <= mem_rdata;
    end
  end
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;
  assign w_wr_be   = w_lane_be;
  assign w_wr_data = w_rep_data;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode, strobes and datapath controls.
  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_load_wait = 1'b0;
    w_dec_wait  = 1'b0;
    w_err_set   = 1'b0;
    w_err_val   = ERR_OK;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
`ifdef STORE_RMW_EN
    w_cap_rdata = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_latch = 1'b1;
          w_next  = CHECK;
        end
      end
      CHECK: begin
        w_load_wait = 1'b1;
        if (!w_valid_op) begin
          w_next    = FIN;
          w_err_set = 1'b1;
          w_err_val = ERR_OK;
        end else if (w_misaligned) begin
          w_next    = FIN;
          w_err_set = 1'b1;
          w_err_val = ERR_MIS;
`ifdef STORE_RMW_EN
        end else if (!w_is_sw) begin
          w_next = READ;
`endif
        end else begin
          w_next = WRITE;
        end
      end
`ifdef STORE_RMW_EN
      READ: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          w_cap_rdata = 1'b1;
          w_load_wait = 1'b1;
          w_next      = WRITE;
        end else if (r_wait == '0) begin
          w_next    = FIN;
          w_err_set = 1'b1;
          w_err_val = ERR_TO;
        end else begin
          w_dec_wait = 1'b1;
        end
      end
`endif
      WRITE: begin
        mem_wr = 1'b1;
        if (mem_ready) begin
          w_next    = FIN;
          w_err_set = 1'b1;
          w_err_val = ERR_OK;
        end else if (r_wait == '0) begin
          w_next    = FIN;
          w_err_set = 1'b1;
          w_err_val = ERR_TO;
        end else begin
          w_dec_wait = 1'b1;
        end
      end
      FIN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request latch, wait counter and completion status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= 6'h0;
      r_addr   <= 32'h0;
      r_din    <= 32'h0;
      r_wait   <= '0;
      r_err    <= ERR_OK;
    end else begin
      if (w_latch) begin
        r_opcode <= opcode;
        r_addr   <= addr;
        r_din    <= din;
        r_err    <= ERR_OK;
      end
      if (w_load_wait) begin
        r_wait <= CW'(WAIT_MAX - 1);
      end else if (w_dec_wait) begin
        r_wait <= r_wait - CW'(1);
      end
      if (w_err_set) begin
        r_err <= w_err_val;
      end
    end
  end

  assign w_access  = mem_rd | mem_wr;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_be    = mem_wr ? w_wr_be : (w_access ? 4'b1111 : 4'b0000);
  assign mem_wdata = mem_wr ? w_wr_data : 32'h0;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign err       = r_err;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a scoreboard of expected store results.
module tb_store_unit;
  localparam int WAIT_MAX = 15;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SB = 6'b101000;
  localparam logic [31:0] RDATA = 32'h1122_3344;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  store_unit #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr), .din(din),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  err;
    int          wr;
    int          rd;
    int          lat;
  } res_t;

  res_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result of one store, built byte by byte from the store size and offset.
  function automatic res_t model(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] d, input bit rdy);
    res_t e;
    int n;
    int off;
    bit rmw;
    logic [31:0] rep;
    e.addr = 32'h0; e.wdata = 32'h0; e.be = 4'h0; e.err = 2'b00;
    e.wr = 0; e.rd = 0; e.lat = 2;
    off = int'(a[1:0]);
    rep = 32'h0;
    if (op == SW) begin n = 4; rep = d; end
    else if (op == SH) begin n = 2; rep = {d[15:0], d[15:0]}; end
    else if (op == SB) begin n = 1; rep = {d[7:0], d[7:0], d[7:0], d[7:0]}; end
    else n = 0;
    if (n == 0) return e;
    if ((off % n) != 0) begin
      e.err = 2'b01;
      return e;
    end
`ifdef STORE_RMW_EN
    rmw = (n < 4);
`else
    rmw = 1'b0;
`endif
    e.addr = {a[31:2], 2'b00};
    for (int k = 0; k < n; k++) e.be[off + k] = 1'b1;
    if (rmw) begin
      for (int l = 0; l < 4; l++) e.wdata[8*l +: 8] = e.be[l] ? rep[8*l +: 8] : RDATA[8*l +: 8];
      e.be = 4'hF;
    end else begin
      e.wdata = rep;
    end
    if (!rdy) begin
      e.err = 2'b10;
      e.lat = 2 + WAIT_MAX;
      if (rmw) begin
        e.rd = WAIT_MAX; e.be = 4'h0; e.wdata = 32'h0;
      end else begin
        e.wr = WAIT_MAX;
      end
    end else begin
      e.wr = 1;
      e.rd = rmw ? 1 : 0;
      e.lat = rmw ? 4 : 3;
    end
    return e;
  endfunction

  // Issue one store, watch the port until done, then compare against the scoreboard.
  task automatic run_store(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] d, input bit rdy, output res_t got);
    res_t e;
    bit seen;
    bit stable;
    bit first;
    sb_q.push_back(model(op, a, d, rdy));
    got.addr = 32'h0; got.wdata = 32'h0; got.be = 4'h0; got.err = 2'b00;
    got.wr = 0; got.rd = 0; got.lat = 0;
    mem_ready = rdy;
    @(negedge clk);
    start = 1'b1; opcode = op; addr = a; din = d;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
    seen = 1'b0; stable = 1'b1; first = 1'b1;
    for (int lat = 1; lat < 100 && !seen; lat++) begin
      if (mem_wr) begin
        if (!first && (mem_be !== got.be || mem_wdata !== got.wdata || mem_addr !== got.addr))
          stable = 1'b0;
        first = 1'b0;
        got.wr++; got.be = mem_be; got.wdata = mem_wdata; got.addr = mem_addr;
      end
      if (mem_rd) begin
        got.rd++; got.addr = mem_addr;
      end
      if (done) begin
        seen = 1'b1; got.err = err; got.lat = lat;
        chk({tag, "_strobe_at_done"}, {30'h0, mem_rd, mem_wr}, 32'h0);
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
    e = sb_q.pop_front();
    chk({tag, "_err"}, {30'h0, got.err}, {30'h0, e.err});
    chk({tag, "_lat"}, got.lat, e.lat);
    chk({tag, "_wr_cycles"}, got.wr, e.wr);
    chk({tag, "_rd_cycles"}, got.rd, e.rd);
    chk({tag, "_be"}, {28'h0, got.be}, {28'h0, e.be});
    chk({tag, "_wdata"}, got.wdata, e.wdata);
    chk({tag, "_addr"}, got.addr, e.addr);
    chk({tag, "_stable"}, {31'h0, stable}, 32'h1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    res_t r;
    res_t e;
    int   dones;
    logic [31:0] wr_addr;
    rst = 1'b1; start = 1'b0; opcode = 6'h0; addr = 32'h0; din = 32'h0;
    mem_ready = 1'b0; mem_rdata = RDATA;
    #1;
    chk("rst_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_busy_done_err", {28'h0, busy, done, err}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_store("sb_1002", SB, 32'h0000_1002, 32'h0000_00A5, 1'b1, r);
`ifndef STORE_RMW_EN
    chk("sb_1002_be_const", {28'h0, r.be}, 32'h4);
    chk("sb_1002_wdata_const", r.wdata, 32'hA5A5_A5A5);
    chk("sb_1002_lat_const", r.lat, 3);
`endif
    chk("sb_1002_addr_const", r.addr, 32'h0000_1000);

    run_store("sh_2003_mis", SH, 32'h0000_2003, 32'h0000_1234, 1'b1, r);
    chk("sh_2003_err_const", {30'h0, r.err}, 32'h1);

    run_store("sh_0012", SH, 32'h0000_0012, 32'h0000_BEEF, 1'b1, r);
`ifdef STORE_RMW_EN
    chk("sh_0012_rmw_wdata_const", r.wdata, 32'hBEEF_3344);
    chk("sh_0012_rmw_be_const", {28'h0, r.be}, 32'hF);
`else
    chk("sh_0012_be_const", {28'h0, r.be}, 32'hC);
`endif

    run_store("sw_aligned", SW, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, r);
    run_store("sh_low", SH, 32'h0000_0204, 32'h1234_5678, 1'b1, r);
    run_store("sb_off1", SB, 32'h0000_0301, 32'h0000_005A, 1'b1, r);
    run_store("sb_off3", SB, 32'h0000_0303, 32'h0000_00C3, 1'b1, r);
    run_store("sw_mis1", SW, 32'h0000_0401, 32'h1111_1111, 1'b1, r);
    run_store("sw_mis2", SW, 32'h0000_0402, 32'h2222_2222, 1'b1, r);
    run_store("bad_opcode", 6'b100011, 32'h0000_0500, 32'h3333_3333, 1'b1, r);

    run_store("sw_timeout", SW, 32'h0000_0600, 32'h4444_4444, 1'b0, r);
    chk("sw_timeout_err_const", {30'h0, r.err}, 32'h2);
    chk("sw_timeout_wr_const", r.wr, 15);
    run_store("sb_timeout", SB, 32'h0000_0702, 32'h0000_0077, 1'b0, r);

    // Reset in the middle of a stalled write.
    mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = SW; addr = 32'h0000_0800; din = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midwr_wr_high", {31'h0, mem_wr}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midwr_rst_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    chk("midwr_rst_busy_done", {30'h0, busy, done}, 32'h0);
    chk("midwr_rst_be", {28'h0, mem_be}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midwr_after_rst_idle", {29'h0, busy, mem_rd, mem_wr}, 32'h0);
    run_store("after_rst_sw", SW, 32'h0000_0900, 32'h6666_7777, 1'b1, r);

    // Start pulses while busy must be ignored.
    mem_ready = 1'b1;
    sb_q.push_back(model(SW, 32'h0000_3000, 32'hCAFE_F00D, 1'b1));
    dones = 0; wr_addr = 32'h0;
    @(negedge clk);
    start = 1'b1; opcode = SW; addr = 32'h0000_3000; din = 32'hCAFE_F00D;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (mem_wr) wr_addr = mem_addr;
      start = (i == 1 || i == 2);
      addr = 32'h0000_4000 + 32'(i) * 32'h100;
    end
    e = sb_q.pop_front();
    chk("busy_start_dones", dones, 1);
    chk("busy_start_wr_addr", wr_addr, e.addr);

    for (int i = 0; i < 8; i++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 2);
      op = (sel == 0) ? SW : ((sel == 1) ? SH : SB);
      run_store("rand", op, $urandom, $urandom, 1'b1, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
